// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the product accumulator slice.
//   PROD_W  : width of the unsigned product coming from the 4x4 multiplier.
//   state_t : control FSM state encoding used by product_accumulator.
// No ports (package).
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage : mult_pkg

// File: rtl/acc_add.sv
// -----------------------------------------------------------------------------
// acc_add
// ACC_W-bit adder that adds a zero-extended product to the running
// accumulator and reports the carry out of the top bit.
// Build option: when ACC_SATURATE_EN is defined, a carry clamps the result
// to all ones; otherwise the result wraps modulo 2^ACC_W.
// Ports:
//   i_acc    [ACC_W-1:0]  current accumulator value
//   i_prod   [PROD_W-1:0] unsigned product to add
//   o_sum    [ACC_W-1:0]  new accumulator value (wrapped or clamped)
//   o_carry               carry out of bit ACC_W-1
// -----------------------------------------------------------------------------
module acc_add
    import mult_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_carry
);

    logic [ACC_W:0]   w_full;
    logic [ACC_W-1:0] w_raw;

    assign w_full  = {1'b0, i_acc} + (ACC_W + 1)'(i_prod);
    assign w_raw   = w_full[ACC_W-1:0];
    assign o_carry = w_full[ACC_W];

`ifdef ACC_SATURATE_EN
    // Once clamped at all ones, any later non-zero product carries again and
    // zero products leave the value unchanged, so the clamp persists.
    assign o_sum = o_carry ? {ACC_W{1'b1}} : w_raw;
`else
    assign o_sum = w_raw;
`endif

endmodule : acc_add

// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
// Sums a batch of 8-bit products into an ACC_W-bit accumulator. A batch ends
// on in_last or after MAX_TERMS terms; the result is then held on
// sum/cnt/ovf with out_valid until the downstream takes it with out_ready.
// Build option: ACC_SATURATE_EN (see acc_add) selects clamp-on-overflow
// instead of wrap-around; ovf is sticky per batch in both builds.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for first term of a batch, in_ready=1
// ST_ACCUM | batch open, adding terms, in_ready=1
// ST_HOLD  | result held, out_valid=1, in_ready=0
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   p          [7:0] unsigned product
//   in_valid   p/in_last valid
//   in_last    current term closes the batch
//   in_ready   term accepted when in_valid && in_ready
//   sum        [ACC_W-1:0] batch sum (registered)
//   cnt        [$clog2(MAX_TERMS+1)-1:0] terms in batch
//   ovf        sticky overflow flag for the batch
//   out_valid  result held on sum/cnt/ovf
//   out_ready  downstream consumes the result
// -----------------------------------------------------------------------------
module product_accumulator
    import mult_pkg::*;
#(
    parameter int ACC_W     = 12,
    parameter int MAX_TERMS = 16,
    localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] p,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ACC_W-1:0]  sum,
    output logic [CNT_W-1:0]  cnt,
    output logic              ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_accept;
    logic [ACC_W-1:0] w_add_sum;
    logic             w_add_carry;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_close_first;
    logic             w_close_accum;

    acc_add #(
        .ACC_W (ACC_W)
    ) u_acc_add (
        .i_acc   (r_acc),
        .i_prod  (p),
        .o_sum   (w_add_sum),
        .o_carry (w_add_carry)
    );

    assign w_accept  = in_valid && r_in_ready;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // A single-term batch size closes on the very first term.
    assign w_close_first = in_last || (MAX_TERMS == 1);
    assign w_close_accum = in_last || (w_cnt_inc == MAX_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_acc <= ACC_W'(p);
                        r_cnt <= CNT_W'(1);
                        r_ovf <= 1'b0;
                        if (w_close_first) begin
                            r_state     <= ST_HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                    end
                end

                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_add_sum;
                        r_cnt <= w_cnt_inc;
                        r_ovf <= r_ovf | w_add_carry;
                        if (w_close_accum) begin
                            r_state     <= ST_HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end

                ST_HOLD: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_acc;
    assign cnt       = r_cnt;
    assign ovf       = r_ovf;

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    localparam int ACC_W  = 12;
    localparam int MT     = 16;
    localparam int CW     = $clog2(MT + 1);
    localparam int ACC_W2 = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (defaults)
    logic             rst, in_valid, in_last, out_ready;
    logic [7:0]       p;
    logic             in_ready, ovf, out_valid;
    logic [ACC_W-1:0] sum;
    logic [CW-1:0]    cnt;

    // narrow instance for overflow
    logic              rst2, in_valid2, in_last2, out_ready2;
    logic [7:0]        p2;
    logic              in_ready2, ovf2, out_valid2;
    logic [ACC_W2-1:0] sum2;
    logic [CW-1:0]     cnt2;

    product_accumulator #(.ACC_W(ACC_W), .MAX_TERMS(MT)) dut (
        .clk(clk), .rst(rst), .p(p), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .sum(sum), .cnt(cnt), .ovf(ovf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    product_accumulator #(.ACC_W(ACC_W2), .MAX_TERMS(MT)) dut10 (
        .clk(clk), .rst(rst2), .p(p2), .in_valid(in_valid2), .in_last(in_last2),
        .in_ready(in_ready2), .sum(sum2), .cnt(cnt2), .ovf(ovf2),
        .out_valid(out_valid2), .out_ready(out_ready2)
    );

    typedef struct {
        logic             v;
        logic             last;
        logic [7:0]       p;
        logic             ordy;
        logic             e_ir;
        logic             e_ov;
        logic             chk_d;
        logic [ACC_W-1:0] e_sum;
        logic [CW-1:0]    e_cnt;
        logic             e_ovf;
    } vec_t;

    vec_t tbl[$];
    int n_pass = 0;
    int n_total = 0;

    function automatic vec_t mk(logic v, logic last, int pv, logic ordy,
                                logic e_ir, logic e_ov, logic chk_d,
                                int e_sum, int e_cnt, logic e_ovf);
        vec_t r;
        r.v = v; r.last = last; r.p = 8'(pv); r.ordy = ordy;
        r.e_ir = e_ir; r.e_ov = e_ov; r.chk_d = chk_d;
        r.e_sum = ACC_W'(e_sum); r.e_cnt = CW'(e_cnt); r.e_ovf = e_ovf;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic drive(input logic v, input logic last, input int pv, input logic ordy);
        in_valid = v; in_last = last; p = 8'(pv); out_ready = ordy;
        @(posedge clk); #1;
    endtask

    task automatic drive2(input logic v, input logic last, input int pv, input logic ordy);
        in_valid2 = v; in_last2 = last; p2 = 8'(pv); out_ready2 = ordy;
        @(posedge clk); #1;
    endtask

    task automatic chk_main(input string nm, input logic e_ir, input logic e_ov,
                            input int e_sum, input int e_cnt, input logic e_ovf);
        chk({nm, ".in_ready"}, int'(in_ready), int'(e_ir));
        chk({nm, ".out_valid"}, int'(out_valid), int'(e_ov));
        chk({nm, ".sum"}, int'(sum), e_sum);
        chk({nm, ".cnt"}, int'(cnt), e_cnt);
        chk({nm, ".ovf"}, int'(ovf), int'(e_ovf));
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_last = 0; p = 0; out_ready = 0;
        rst2 = 1'b1; in_valid2 = 0; in_last2 = 0; p2 = 0; out_ready2 = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_main("reset", 1'b1, 1'b0, 0, 0, 1'b0);
        rst = 1'b0; rst2 = 1'b0;

        // single term 225
        tbl.push_back(mk(1, 1, 225, 0, 0, 1, 1, 225, 1, 0));
        tbl.push_back(mk(0, 0, 0,   1, 1, 0, 0, 0,   0, 0));
        // 10,20,30,40 with out_ready high throughout
        tbl.push_back(mk(1, 0, 10, 1, 1, 0, 0, 0,   0, 0));
        tbl.push_back(mk(1, 0, 20, 1, 1, 0, 0, 0,   0, 0));
        tbl.push_back(mk(1, 0, 30, 1, 1, 0, 0, 0,   0, 0));
        tbl.push_back(mk(1, 1, 40, 1, 0, 1, 1, 100, 4, 0));
        tbl.push_back(mk(0, 0, 0,  1, 1, 0, 0, 0,   0, 0));
        // held result with a pending term and out_ready low for 5 cycles
        tbl.push_back(mk(1, 1, 7, 0, 0, 1, 1, 7, 1, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 1, 9, 0, 0, 1, 1, 7, 1, 0));
        tbl.push_back(mk(1, 1, 9, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 9, 0, 0, 1, 1, 9, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].last, int'(tbl[i].p), tbl[i].ordy);
            chk($sformatf("vec%0d.in_ready", i), int'(in_ready), int'(tbl[i].e_ir));
            chk($sformatf("vec%0d.out_valid", i), int'(out_valid), int'(tbl[i].e_ov));
            if (tbl[i].chk_d) begin
                chk($sformatf("vec%0d.sum", i), int'(sum), int'(tbl[i].e_sum));
                chk($sformatf("vec%0d.cnt", i), int'(cnt), int'(tbl[i].e_cnt));
                chk($sformatf("vec%0d.ovf", i), int'(ovf), int'(tbl[i].e_ovf));
            end
        end

        // forced close after MAX_TERMS terms of 225
        for (int i = 0; i < MT - 1; i++) drive(1, 0, 225, 0);
        chk("force.pre_in_ready", int'(in_ready), 1);
        chk("force.pre_out_valid", int'(out_valid), 0);
        chk("force.pre_cnt", int'(cnt), MT - 1);
        drive(1, 0, 225, 0);
        chk_main("force", 1'b0, 1'b1, 3600, 16, 1'b0);
        drive(1, 0, 99, 0);
        chk_main("force_hold", 1'b0, 1'b1, 3600, 16, 1'b0);
        drive(0, 0, 0, 1);
        chk("force.release", int'(out_valid), 0);

        // reset mid-batch, with a term offered in the reset cycle
        drive(1, 0, 1, 0);
        drive(1, 0, 2, 0);
        rst = 1'b1;
        drive(1, 0, 3, 1);
        rst = 1'b0;
        chk_main("rst_mid", 1'b1, 1'b0, 0, 0, 1'b0);
        drive(1, 0, 5, 0);
        drive(1, 1, 6, 0);
        chk_main("after_rst", 1'b0, 1'b1, 11, 2, 1'b0);
        // reset while holding beats out_ready
        rst = 1'b1;
        drive(0, 0, 0, 1);
        rst = 1'b0;
        chk_main("rst_hold", 1'b1, 1'b0, 0, 0, 1'b0);

        // overflow on the 10-bit instance
        for (int i = 0; i < 4; i++) drive2(1, 0, 225, 0);
        chk("ovf10.pre_ovf", int'(ovf2), 0);
        chk("ovf10.pre_sum", int'(sum2), 900);
        drive2(1, 1, 225, 0);
        chk("ovf10.out_valid", int'(out_valid2), 1);
        chk("ovf10.ovf", int'(ovf2), 1);
        chk("ovf10.cnt", int'(cnt2), 5);
`ifdef ACC_SATURATE_EN
        chk("ovf10.sum", int'(sum2), 1023);
`else
        chk("ovf10.sum", int'(sum2), 101);
`endif
        drive2(0, 0, 0, 1);
        chk("ovf10.release", int'(out_valid2), 0);
        chk("ovf10.sticky_idle", int'(ovf2), 1);
        drive2(1, 1, 3, 0);
        chk("ovf10.clear_ovf", int'(ovf2), 0);
        chk("ovf10.clear_sum", int'(sum2), 3);
        drive2(0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_product_accumulator

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 12, accumulator/sum width in bits (ACC_W >= 8).
REQ-002 SHALL have parameter MAX_TERMS, default 16, maximum products per batch (>= 1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port p  input  8  unsigned product from the upstream 4x4 multiplier.
REQ-006 SHALL have port in_valid  input  1  p/in_last valid this cycle.
REQ-007 SHALL have port in_last  input  1  current term closes the batch.
REQ-008 SHALL have port in_ready  output  1  block accepts a term this cycle.
REQ-009 SHALL have port sum  output  ACC_W  batch sum, valid while out_valid.
REQ-010 SHALL have port cnt  output  $clog2(MAX_TERMS+1)  number of terms in the batch.
REQ-011 SHALL have port ovf  output  1  sticky per-batch overflow flag.
REQ-012 SHALL have port out_valid  output  1  result held on sum/cnt/ovf.
REQ-013 SHALL have port out_ready  input  1  downstream consumes the result.

Function
REQ-014 SHALL accept a term only on a cycle with in_valid && in_ready (accept).
REQ-015 SHALL implement FSM IDLE, ACCUM, HOLD; in_ready=1 in IDLE/ACCUM, 0 in HOLD; out_valid=1 only in HOLD.
REQ-016 IDLE + accept: acc<=zero-extended p, cnt<=1, ovf<=0; next ACCUM, or HOLD if in_last or MAX_TERMS==1.
REQ-017 ACCUM + accept: acc<=acc+p, cnt<=cnt+1, ovf<=ovf|carry-out; next HOLD if in_last or cnt+1==MAX_TERMS, else stay ACCUM.
REQ-018 ACCUM/IDLE without accept: all state held.
REQ-019 HOLD: sum/cnt/ovf stable; out_valid && out_ready -> IDLE next cycle, out_valid=0 that cycle.
REQ-020 Latency: result visible on out_valid the cycle after the closing term is accepted.
REQ-021 No same-cycle bypass: a term offered while in HOLD is not accepted until the cycle in IDLE after release.
REQ-022 sum SHALL equal the accumulator register directly (registered output, no combinational path from p).
REQ-023 Overflow: carry out of bit ACC_W-1 sets ovf; ovf clears only at first term of next batch or reset.

Reset
REQ-024 rst SHALL force state IDLE, sum=0, cnt=0, ovf=0, out_valid=0, in_ready=1 on the following cycle.
REQ-025 rst mid-batch or in HOLD SHALL discard the partial/held result; rst has priority over accept and out_ready.

Configuration
REQ-026 Macro ACC_SATURATE_EN defined: on overflow acc SHALL clamp to 2^ACC_W-1 and remain clamped for the batch.
REQ-027 Macro ACC_SATURATE_EN undefined: acc SHALL wrap modulo 2^ACC_W; ovf behaves per REQ-023 in both builds.

Structure
REQ-028 Shared package mult_pkg SHALL hold the FSM state enum typedef and the product width constant PROD_W=8.
REQ-029 Single sub-module acc_add SHALL implement the ACC_W adder with carry-out and optional saturation; FSM in top.

Verification
REQ-030 Single term p=225, in_last=1 -> next cycle out_valid=1, sum=225, cnt=1, ovf=0.
REQ-031 Terms 10,20,30,40 (last on 40), out_ready=1 -> sum=100, cnt=4, out_valid exactly one cycle.
REQ-032 16 terms of 225, in_last never set -> forced close, sum=3600, cnt=16, ovf=0, in_ready=0 in HOLD.
REQ-033 Hold out_ready=0 for 5 cycles with in_valid=1 pending -> sum/cnt stable, no accept until IDLE, then pending term starts new batch.
REQ-034 ACC_W=10, 5x225 -> ovf=1; sum=101 without ACC_SATURATE_EN, sum=1023 with it.
REQ-035 rst after 2 of 4 terms -> all outputs 0 next cycle; fresh batch 5,6 (last) -> sum=11, cnt=2.
